// File: rtl/stack_pkg.sv
// stack_pkg: command, fault and state encodings shared by the operand stack
package stack_pkg;
    typedef enum logic [2:0] {
        CMD_NOP   = 3'b000,
        CMD_PUSH  = 3'b001,
        CMD_DROP  = 3'b010,
        CMD_DUP   = 3'b011,
        CMD_SWAP  = 3'b100,
        CMD_BINOP = 3'b101
    } cmd_e;
    typedef enum logic [1:0] {
        F_ILLEGAL   = 2'b00,
        F_UNDERFLOW = 2'b01,
        F_OVERFLOW  = 2'b10,
        F_DIVZERO   = 2'b11
    } fault_e;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        FAULT = 2'b10
    } state_e;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
endpackage

// File: rtl/operand_stack_if.sv
// operand_stack_if: decoder command handshake, ALU operand/result bus and status
interface operand_stack_if #(
    parameter int CELL_SIZE = 16,
    parameter int DEPTH = 16
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [2:0]                   cmd;
    logic [2:0]                   cmd_op;
    logic [CELL_SIZE-1:0]         cmd_data;
    logic [2:0]                   alu_op;
    logic [CELL_SIZE-1:0]         alu_lhs;
    logic [CELL_SIZE-1:0]         alu_rhs;
    logic [CELL_SIZE-1:0]         alu_result;
    logic [CELL_SIZE-1:0]         tos;
    logic [$clog2(DEPTH+1)-1:0]   depth;
    logic                         fault;
    logic [1:0]                   fault_code;
    logic                         fault_clear;
    modport slave (
        input  cmd_valid, cmd, cmd_op, cmd_data, alu_result, fault_clear,
        output cmd_ready, alu_op, alu_lhs, alu_rhs, tos, depth, fault, fault_code
    );
    modport master (
        output cmd_valid, cmd, cmd_op, cmd_data, alu_result, fault_clear,
        input  cmd_ready, alu_op, alu_lhs, alu_rhs, tos, depth, fault, fault_code
    );
endinterface

// File: rtl/stack_mem.sv
// stack_mem: cell array with TOS/NOS async reads and two write ports for SWAP
module stack_mem #(
    parameter int CELL_SIZE = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         we0,
    input  logic [$clog2(DEPTH)-1:0]     wa0,
    input  logic [CELL_SIZE-1:0]         wd0,
    input  logic                         we1,
    input  logic [$clog2(DEPTH)-1:0]     wa1,
    input  logic [CELL_SIZE-1:0]         wd1,
    input  logic [$clog2(DEPTH)-1:0]     ra0,
    input  logic [$clog2(DEPTH)-1:0]     ra1,
    output logic [CELL_SIZE-1:0]         rd0,
    output logic [CELL_SIZE-1:0]         rd1
);
    logic [CELL_SIZE-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we0) mem_q[wa0] <= wd0;
        if (we1) mem_q[wa1] <= wd1;
    end
    assign rd0 = mem_q[ra0];
    assign rd1 = mem_q[ra1];
endmodule

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack feeding the ALU, with sticky fault handling
module operand_stack
    import stack_pkg::*;
#(
    parameter int CELL_SIZE = 16,
    parameter int DEPTH = 16
) (
    input logic clk,
    input logic rst,
    operand_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] TWO = DW'(2);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_FAULT = FAULT;
    logic [1:0]           state_q, state_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [2:0]           alu_op_q, alu_op_d;
    logic [CELL_SIZE-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
    logic [1:0]           fault_code_q, fault_code_d;
    logic [CELL_SIZE-1:0] tos_rd, nos_rd, wd0, wd1;
    logic [AW-1:0]        tos_addr, nos_addr, push_addr, wa0;
    logic                 we0, we1, exec;
    logic                 accept, ok, err, under, over, divz, illegal;
    logic                 is_push, is_drop, is_dup, is_swap, is_binop;
    logic [1:0]           err_code;
    stack_mem #(.CELL_SIZE(CELL_SIZE), .DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(nos_addr), .wd1(wd1),
        .ra0(tos_addr), .ra1(nos_addr),
        .rd0(tos_rd), .rd1(nos_rd)
    );
    always_comb begin
        tos_addr  = AW'(depth_q - ONE);
        nos_addr  = AW'(depth_q - TWO);
        push_addr = AW'(depth_q);
        exec      = state_q == S_EXEC;
        accept    = state_q == S_IDLE && bus.cmd_valid;
        is_push   = bus.cmd == CMD_PUSH;
        is_drop   = bus.cmd == CMD_DROP;
        is_dup    = bus.cmd == CMD_DUP;
        is_swap   = bus.cmd == CMD_SWAP;
        is_binop  = bus.cmd == CMD_BINOP;
        illegal   = bus.cmd[2:1] == 2'b11;
        under     = ((is_drop || is_dup) && depth_q == '0) || ((is_swap || is_binop) && depth_q < TWO);
        over      = (is_push || is_dup) && depth_q == FULL;
        divz      = is_binop && (bus.cmd_op == OP_DIV || bus.cmd_op == OP_MOD) && tos_rd == '0;
        err       = illegal || under || over || divz;
        err_code  = illegal ? F_ILLEGAL : under ? F_UNDERFLOW : over ? F_OVERFLOW : F_DIVZERO;
        ok        = accept && !err;
        state_d   = exec ? S_IDLE
                  : state_q == S_FAULT ? (bus.fault_clear ? S_IDLE : S_FAULT)
                  : accept && err ? S_FAULT
                  : ok && is_binop ? S_EXEC : S_IDLE;
        depth_d   = exec ? depth_q - ONE
                  : !ok ? depth_q
                  : (is_push || is_dup) ? depth_q + ONE
                  : is_drop ? depth_q - ONE : depth_q;
        fault_code_d = accept && err ? err_code : fault_code_q;
        alu_op_d  = ok && is_binop ? bus.cmd_op : alu_op_q;
        lhs_d     = ok && is_binop ? nos_rd : lhs_q;
        rhs_d     = ok && is_binop ? tos_rd : rhs_q;
        // reset during EXEC must not let the pending result reach the array
        we0       = !rst && (exec || (ok && (is_push || is_dup || is_swap)));
        wa0       = exec ? nos_addr : is_swap ? tos_addr : push_addr;
        wd0       = exec ? bus.alu_result : is_swap ? nos_rd : is_push ? bus.cmd_data : tos_rd;
        we1       = !rst && ok && is_swap;
        wd1       = tos_rd;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            depth_q      <= '0;
            alu_op_q     <= '0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            fault_code_q <= '0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            alu_op_q     <= alu_op_d;
            lhs_q        <= lhs_d;
            rhs_q        <= rhs_d;
            fault_code_q <= fault_code_d;
        end
    end
    assign bus.cmd_ready  = state_q == S_IDLE;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_lhs    = lhs_q;
    assign bus.alu_rhs    = rhs_q;
    assign bus.tos        = depth_q == '0 ? '0 : tos_rd;
    assign bus.depth      = depth_q;
    assign bus.fault      = state_q == S_FAULT;
    assign bus.fault_code = fault_code_q;
endmodule
